pc_sequencer: RTL and testbench
===============================

PC_SEQUENCER -- requirements
Module: pc_sequencer

Interface
REQ-001 SHALL have port: clk  input  1  single system clock; all state changes on rising edge.
REQ-002 SHALL have port: reset  input  1  synchronous, active-high reset.
REQ-003 SHALL have port: start  input  1  level; begins execution from PC 0 when in IDLE or HALT.
REQ-004 SHALL have port: branch_dest  input  3  target-table select from decode; 0 = sequential.
REQ-005 SHALL have port: halt  input  1  decoded halt for current instruction.
REQ-006 SHALL have port: skip_flag  input  1  skip-if-not-one instruction.
REQ-007 SHALL have port: if_done_flag  input  1  conditional branch instruction.
REQ-008 SHALL have port: alu_zero  input  1  ALU zero result for current instruction.
REQ-009 SHALL have port: mem_access  input  1  current instruction reads or writes data memory.
REQ-010 SHALL have port: mem_ready  input  1  data memory completes access this cycle.
REQ-011 SHALL have ports: tgt_wr_en  input  1; tgt_wr_idx  input  3; tgt_wr_data  input  8  branch-target table write.
REQ-012 SHALL have port: pc  output  8  current instruction address.
REQ-013 SHALL have port: instr_valid  output  1  decode outputs are to be honoured this cycle.
REQ-014 SHALL have port: commit  output  1  one-cycle pulse; gates register/memory write enables.
REQ-015 SHALL have ports: running  output  1; halted  output  1  status.

Function
REQ-016 SHALL implement states IDLE, FETCH, EXEC, MEMWAIT, HALT.
REQ-017 IDLE: start=1 -> FETCH with pc=0; else remain.
REQ-018 FETCH: one cycle, instr_valid=0, pc stable; always -> EXEC.
REQ-019 EXEC: instr_valid=1; mem_access=1 and mem_ready=0 -> MEMWAIT without commit; otherwise commit=1, pc updated, -> FETCH (halt=1 -> HALT).
REQ-020 MEMWAIT: instr_valid=1, commit=0 until mem_ready=1; then commit=1, pc updated, -> FETCH (or HALT).
REQ-021 Next-PC priority: halt (pc unchanged) > skip_flag (pc + (alu_zero ? 1 : 2)) > if_done_flag (alu_zero ? table[branch_dest] : pc+1) > branch_dest!=0 (table[branch_dest]) > pc+1.
REQ-022 PC arithmetic SHALL be 8-bit modulo 256; 255+1 -> 0, 255+2 -> 1.
REQ-023 Table: 8 x 8-bit, written on tgt_wr_en any state; read and write same index same cycle returns old value.
REQ-024 Minimum latency SHALL be 2 cycles per instruction; each MEMWAIT cycle adds 1.
REQ-025 HALT: halted=1, pc frozen; start=1 -> FETCH with pc=0.
REQ-026 running=1 in FETCH, EXEC, MEMWAIT; commit never asserted outside EXEC/MEMWAIT.

Reset
REQ-027 On reset: state=IDLE, pc=0, instr_valid=0, commit=0, running=0, halted=0.
REQ-028 Table resets to 0 for all entries except entry 6 = 200 (halt vector).
REQ-029 Reset during MEMWAIT or EXEC SHALL suppress commit in that cycle; reset dominates start.

Configuration
REQ-030 With PC_SEQ_RETIRE_CNT_EN defined: output retire_cnt (16-bit) increments on each commit, saturates at 65535, clears on reset and on start-from-HALT.
REQ-031 Without PC_SEQ_RETIRE_CNT_EN: no retire_cnt port, no counter logic.

Structure
REQ-032 Package pc_seq_pkg SHALL hold state enum, PC_W=8, N_TGT=8, HALT_PC=200, branch_dest encodings.
REQ-033 Table SHALL be sub-module branch_target_table; FSM and next-PC logic in pc_sequencer.

Verification
REQ-034 reset, start pulse, 3 sequential instrs (branch_dest=0) -> pc 0,1,2,3; commit every 2nd cycle.
REQ-035 pc=10, mem_access=1, mem_ready low 3 cycles -> 3 MEMWAIT cycles, single commit, pc=11.
REQ-036 pc=20, skip_flag=1, alu_zero=0 -> pc=22; alu_zero=1 -> pc=21; pc=255 skip not-one -> pc=1.
REQ-037 table[3]=40 written; if_done_flag=1, branch_dest=3, alu_zero=1 -> pc=40; alu_zero=0 -> pc+1.
REQ-038 branch_dest=6 after reset -> pc=200; halt=1 with branch_dest=4 -> HALT, pc unchanged, halted=1.
REQ-039 reset asserted in MEMWAIT -> no commit, next cycle IDLE, pc=0.

Source files
------------

// File: rtl/pc_seq_pkg.sv
// Shared types and constants for the program-counter sequencer.
// Optional feature macro: PC_SEQ_RETIRE_CNT_EN adds a saturating retire counter.
package pc_seq_pkg;

  localparam int unsigned PC_W      = 8;
  localparam int unsigned N_TGT     = 8;
  localparam int unsigned TGT_IDX_W = 3;
  localparam int unsigned HALT_PC   = 200;

`ifdef PC_SEQ_RETIRE_CNT_EN
  localparam int unsigned RETIRE_W  = 16;
`endif

  // branch_dest encodings
  localparam logic [TGT_IDX_W-1:0] BD_SEQ      = TGT_IDX_W'(0);
  localparam logic [TGT_IDX_W-1:0] BD_HALT_VEC = TGT_IDX_W'(6);

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_FETCH,
    ST_EXEC,
    ST_MEMWAIT,
    ST_HALT
  } state_e;

  typedef struct packed {
    logic                 en;
    logic [TGT_IDX_W-1:0] idx;
    logic [PC_W-1:0]      data;
  } tgt_wr_t;

  // Power-on contents of the branch-target table: all zero except the halt vector.
  function automatic logic [PC_W-1:0] tgt_reset_val(input int unsigned i);
    return (i == 32'(BD_HALT_VEC)) ? PC_W'(HALT_PC) : '0;
  endfunction

endpackage

// File: rtl/branch_target_table.sv
// 8-entry branch-target table; combinational read returns pre-write contents.
module branch_target_table
  import pc_seq_pkg::*;
(
  input  logic                 clk,
  input  logic                 reset,
  input  tgt_wr_t              wr,
  input  logic [TGT_IDX_W-1:0] rd_idx,
  output logic [PC_W-1:0]      rd_data_c
);

  logic [PC_W-1:0] tbl_q [N_TGT];
  logic [PC_W-1:0] tbl_d [N_TGT];

  // Apply a single-entry write to the next-state copy.
  always_comb begin
    tbl_d = tbl_q;
    if (wr.en) begin
      tbl_d[wr.idx] = wr.data;
    end
  end

  // Table storage with synchronous reset to the power-on contents.
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int unsigned i = 0; i < N_TGT; i++) begin
        tbl_q[TGT_IDX_W'(i)] <= tgt_reset_val(i);
      end
    end else begin
      tbl_q <= tbl_d;
    end
  end

  assign rd_data_c = tbl_q[rd_idx];

endmodule

// File: rtl/pc_sequencer.sv
// Instruction sequencer: fetch/exec/memwait FSM plus next-PC selection.
// Optional feature macro: PC_SEQ_RETIRE_CNT_EN adds output retire_cnt.
module pc_sequencer
  import pc_seq_pkg::*;
(
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 start,
  input  logic [TGT_IDX_W-1:0] branch_dest,
  input  logic                 halt,
  input  logic                 skip_flag,
  input  logic                 if_done_flag,
  input  logic                 alu_zero,
  input  logic                 mem_access,
  input  logic                 mem_ready,
  input  logic                 tgt_wr_en,
  input  logic [TGT_IDX_W-1:0] tgt_wr_idx,
  input  logic [PC_W-1:0]      tgt_wr_data,
  output logic [PC_W-1:0]      pc,
  output logic                 instr_valid,
  output logic                 commit,
  output logic                 running,
  output logic                 halted
`ifdef PC_SEQ_RETIRE_CNT_EN
  ,
  output logic [RETIRE_W-1:0]  retire_cnt
`endif
);

  state_e          state_q, state_d;
  logic [PC_W-1:0] pc_q, pc_d;
  logic [PC_W-1:0] next_pc_c;
  logic [PC_W-1:0] tgt_c;
  logic            instr_valid_q, instr_valid_d;
  logic            running_q, running_d;
  logic            halted_q, halted_d;
  logic            commit_c;
  tgt_wr_t         tgt_wr;

  assign tgt_wr = '{en: tgt_wr_en, idx: tgt_wr_idx, data: tgt_wr_data};

  branch_target_table u_tbl (
    .clk       (clk),
    .reset     (reset),
    .wr        (tgt_wr),
    .rd_idx    (branch_dest),
    .rd_data_c (tgt_c)
  );

  // Next-PC selection in priority order: halt, skip, conditional, branch, sequential.
  always_comb begin
    next_pc_c = pc_q + PC_W'(1);
    if (halt) begin
      next_pc_c = pc_q;
    end else if (skip_flag) begin
      next_pc_c = pc_q + (alu_zero ? PC_W'(1) : PC_W'(2));
    end else if (if_done_flag) begin
      next_pc_c = alu_zero ? tgt_c : pc_q + PC_W'(1);
    end else if (branch_dest != BD_SEQ) begin
      next_pc_c = tgt_c;
    end
  end

  // Next-state, PC update and commit strobe; reset masks commit in its cycle.
  always_comb begin
    state_d  = state_q;
    pc_d     = pc_q;
    commit_c = 1'b0;
    case (state_q)
      ST_IDLE, ST_HALT: begin
        if (start) begin
          state_d = ST_FETCH;
          pc_d    = '0;
        end
      end
      ST_FETCH: state_d = ST_EXEC;
      ST_EXEC, ST_MEMWAIT: begin
        if (mem_access && !mem_ready) begin
          state_d = ST_MEMWAIT;
        end else begin
          commit_c = 1'b1;
          pc_d     = next_pc_c;
          state_d  = halt ? ST_HALT : ST_FETCH;
        end
      end
      default: state_d = ST_IDLE;
    endcase
    if (reset) begin
      commit_c = 1'b0;
    end
    instr_valid_d = (state_d == ST_EXEC) || (state_d == ST_MEMWAIT);
    running_d     = (state_d == ST_FETCH) || instr_valid_d;
    halted_d      = (state_d == ST_HALT);
  end

  // State, PC and registered status flags.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q       <= ST_IDLE;
      pc_q          <= '0;
      instr_valid_q <= 1'b0;
      running_q     <= 1'b0;
      halted_q      <= 1'b0;
    end else begin
      state_q       <= state_d;
      pc_q          <= pc_d;
      instr_valid_q <= instr_valid_d;
      running_q     <= running_d;
      halted_q      <= halted_d;
    end
  end

  assign pc          = pc_q;
  assign instr_valid = instr_valid_q;
  assign commit      = commit_c;
  assign running     = running_q;
  assign halted      = halted_q;

`ifdef PC_SEQ_RETIRE_CNT_EN
  logic [RETIRE_W-1:0] retire_cnt_q, retire_cnt_d;
  logic                restart_c;

  assign restart_c = start && (state_q == ST_HALT);

  // Saturating retire count, cleared when restarting out of HALT.
  always_comb begin
    retire_cnt_d = retire_cnt_q;
    if (restart_c) begin
      retire_cnt_d = '0;
    end else if (commit_c && (retire_cnt_q != '1)) begin
      retire_cnt_d = retire_cnt_q + RETIRE_W'(1);
    end
  end

  // Retire counter register.
  always_ff @(posedge clk) begin
    if (reset) begin
      retire_cnt_q <= '0;
    end else begin
      retire_cnt_q <= retire_cnt_d;
    end
  end

  assign retire_cnt = retire_cnt_q;
`endif

endmodule

// File: tb/tb_pc_sequencer.sv
// Self-checking bench for pc_sequencer: vector table, hand corner cases, random vs model.
module tb_pc_sequencer;

  logic       clk;
  logic       reset;
  logic       start;
  logic [2:0] branch_dest;
  logic       halt;
  logic       skip_flag;
  logic       if_done_flag;
  logic       alu_zero;
  logic       mem_access;
  logic       mem_ready;
  logic       tgt_wr_en;
  logic [2:0] tgt_wr_idx;
  logic [7:0] tgt_wr_data;
  logic [7:0] pc;
  logic       instr_valid;
  logic       commit;
  logic       running;
  logic       halted;
`ifdef PC_SEQ_RETIRE_CNT_EN
  logic [15:0] retire_cnt;
`endif

  pc_sequencer dut (
    .clk          (clk),
    .reset        (reset),
    .start        (start),
    .branch_dest  (branch_dest),
    .halt         (halt),
    .skip_flag    (skip_flag),
    .if_done_flag (if_done_flag),
    .alu_zero     (alu_zero),
    .mem_access   (mem_access),
    .mem_ready    (mem_ready),
    .tgt_wr_en    (tgt_wr_en),
    .tgt_wr_idx   (tgt_wr_idx),
    .tgt_wr_data  (tgt_wr_data),
    .pc           (pc),
    .instr_valid  (instr_valid),
    .commit       (commit),
    .running      (running),
    .halted       (halted)
`ifdef PC_SEQ_RETIRE_CNT_EN
    ,
    .retire_cnt   (retire_cnt)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [2:0] bd;
    bit         halt;
    bit         skip;
    bit         ifd;
    bit         az;
    bit         mem;
    int         waits;
    bit         wr;
    logic [2:0] wr_idx;
    logic [7:0] wr_data;
    int         exp_pc;
  } vec_t;

  int   n_cmp = 0;
  int   n_bad = 0;
  int   model_tbl [8];
  int   model_pc;
  int   model_retire;
  vec_t tv [20];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic vec_t mk(int bd, bit h, bit s, bit i, bit a, bit m, int w, int e);
    vec_t v;
    v.bd = 3'(bd); v.halt = h; v.skip = s; v.ifd = i; v.az = a; v.mem = m;
    v.waits = w; v.wr = 1'b0; v.wr_idx = '0; v.wr_data = '0; v.exp_pc = e;
    return v;
  endfunction

  // Reference next-PC from the architectural rules, using the model's table copy.
  function automatic int ref_next(int cur, vec_t v);
    if (v.halt) return cur;
    if (v.skip) return (cur + (v.az ? 1 : 2)) % 256;
    if (v.ifd)  return v.az ? model_tbl[v.bd] : (cur + 1) % 256;
    if (v.bd != 0) return model_tbl[v.bd];
    return (cur + 1) % 256;
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_inputs();
    start = 0; branch_dest = '0; halt = 0; skip_flag = 0; if_done_flag = 0;
    alu_zero = 0; mem_access = 0; mem_ready = 0; tgt_wr_en = 0;
    tgt_wr_idx = '0; tgt_wr_data = '0;
  endtask

  task automatic model_reset();
    for (int i = 0; i < 8; i++) model_tbl[i] = (i == 6) ? 200 : 0;
    model_pc = 0;
    model_retire = 0;
  endtask

  task automatic do_reset();
    clear_inputs();
    reset = 1;
    step();
    step();
    reset = 0;
    model_reset();
  endtask

  task automatic do_start(input bit from_halt);
    start = 1;
    step();
    start = 0;
    model_pc = 0;
    if (from_halt) model_retire = 0;
    chk("start_pc", pc, 0);
    chk("start_running", running, 1);
    chk("start_halted", halted, 0);
    chk("start_instr_valid", instr_valid, 0);
  endtask

  task automatic wr_tbl(input int idx, input int data);
    tgt_wr_en = 1; tgt_wr_idx = 3'(idx); tgt_wr_data = 8'(data);
    step();
    tgt_wr_en = 0;
    model_tbl[idx] = data;
  endtask

  // Runs one instruction starting in FETCH; checks strobes each cycle and the resulting PC.
  task automatic exec_instr(input vec_t v, input int exp);
    branch_dest = v.bd; halt = v.halt; skip_flag = v.skip; if_done_flag = v.ifd;
    alu_zero = v.az; mem_access = v.mem; mem_ready = 0; tgt_wr_en = 0;
    #1;
    chk("fetch_instr_valid", instr_valid, 0);
    chk("fetch_commit", commit, 0);
    chk("fetch_pc", pc, 32'(model_pc));
    step();
    chk("exec_instr_valid", instr_valid, 1);
    if (v.mem) begin
      for (int w = 0; w < v.waits; w++) begin
        #1;
        chk("wait_commit", commit, 0);
        step();
        chk("memwait_instr_valid", instr_valid, 1);
        chk("memwait_pc", pc, 32'(model_pc));
      end
      mem_ready = 1;
    end
    tgt_wr_en = v.wr; tgt_wr_idx = v.wr_idx; tgt_wr_data = v.wr_data;
    #1;
    chk("done_commit", commit, 1);
    step();
    clear_inputs();
    model_pc = exp;
    if (v.wr) model_tbl[v.wr_idx] = v.wr_data;
    if (model_retire < 65535) model_retire++;
    chk("next_pc", pc, 32'(exp));
    chk("post_instr_valid", instr_valid, 0);
    if (v.halt) begin
      chk("post_halted", halted, 1);
      chk("post_running", running, 0);
    end else begin
      chk("post_halted", halted, 0);
      chk("post_running", running, 1);
    end
  endtask

  initial begin
    vec_t v;
    int   e;
    reset = 1;
    clear_inputs();
    model_reset();
    do_reset();
    chk("rst_pc", pc, 0);
    chk("rst_instr_valid", instr_valid, 0);
    chk("rst_commit", commit, 0);
    chk("rst_running", running, 0);
    chk("rst_halted", halted, 0);

    wr_tbl(3, 40); wr_tbl(5, 10); wr_tbl(7, 20); wr_tbl(1, 255);
    chk("idle_running", running, 0);
    chk("idle_commit", commit, 0);

    //             bd h s i a m w  exp
    tv[0]  = mk(0, 0, 0, 0, 0, 0, 0, 1);
    tv[1]  = mk(0, 0, 0, 0, 0, 0, 0, 2);
    tv[2]  = mk(0, 0, 0, 0, 0, 0, 0, 3);
    tv[3]  = mk(5, 0, 0, 0, 0, 0, 0, 10);
    tv[4]  = mk(0, 0, 0, 0, 0, 1, 3, 11);
    tv[5]  = mk(7, 0, 0, 0, 0, 0, 0, 20);
    tv[6]  = mk(0, 0, 1, 0, 0, 0, 0, 22);
    tv[7]  = mk(7, 0, 0, 0, 0, 0, 0, 20);
    tv[8]  = mk(0, 0, 1, 0, 1, 0, 0, 21);
    tv[9]  = mk(3, 0, 0, 1, 1, 0, 0, 40);
    tv[10] = mk(3, 0, 0, 1, 0, 0, 0, 41);
    tv[11] = mk(6, 0, 0, 0, 0, 0, 0, 200);
    tv[12] = mk(1, 0, 0, 0, 0, 0, 0, 255);
    tv[13] = mk(0, 0, 1, 0, 0, 0, 0, 1);
    tv[14] = mk(1, 0, 0, 0, 0, 0, 0, 255);
    tv[15] = mk(0, 0, 0, 0, 0, 0, 0, 0);
    tv[16] = mk(3, 0, 1, 1, 1, 0, 0, 1);
    tv[17] = mk(0, 0, 0, 1, 1, 0, 0, 0);
    tv[18] = mk(0, 0, 0, 0, 0, 1, 0, 1);
    tv[19] = mk(4, 1, 0, 0, 0, 0, 0, 1);

    do_start(0);
    for (int i = 0; i < 20; i++) exec_instr(tv[i], tv[i].exp_pc);

    // PC frozen while halted, regardless of decode inputs.
    for (int i = 0; i < 3; i++) begin
      branch_dest = 3'($urandom_range(0, 7)); skip_flag = 1; mem_access = 1;
      step();
      chk("halt_pc_frozen", pc, 1);
      chk("halt_halted", halted, 1);
      chk("halt_commit", commit, 0);
    end
    clear_inputs();

    // Restart from HALT; write and read of the same entry in one cycle sees the old value.
    do_start(1);
    v = mk(2, 0, 0, 0, 0, 0, 0, 0);
    v.wr = 1; v.wr_idx = 3'd2; v.wr_data = 8'd77;
    exec_instr(v, 0);
    exec_instr(mk(2, 0, 0, 0, 0, 0, 0, 0), 77);

    // Randomized instruction stream against the reference model.
    for (int i = 0; i < 150; i++) begin
      v = mk($urandom_range(0, 7), ($urandom_range(0, 15) == 0), ($urandom_range(0, 4) == 0),
             ($urandom_range(0, 3) == 0), $urandom_range(0, 1), ($urandom_range(0, 2) == 0),
             $urandom_range(0, 3), 0);
      v.wr = ($urandom_range(0, 3) == 0);
      v.wr_idx = 3'($urandom_range(0, 7));
      v.wr_data = 8'($urandom_range(0, 255));
      e = ref_next(model_pc, v);
      exec_instr(v, e);
      if (v.halt) do_start(1);
    end
`ifdef PC_SEQ_RETIRE_CNT_EN
    chk("retire_cnt", retire_cnt, 32'(model_retire));
`endif

    // Reset while in MEMWAIT: no commit, returns to IDLE with pc 0.
    do_reset();
    do_start(0);
    exec_instr(mk(0, 0, 0, 0, 0, 0, 0, 0), 1);
    mem_access = 1; mem_ready = 0;
    step();
    step();
    chk("mw_instr_valid", instr_valid, 1);
    reset = 1;
    #1;
    chk("mw_reset_commit", commit, 0);
    step();
    chk("mw_reset_pc", pc, 0);
    chk("mw_reset_running", running, 0);
    chk("mw_reset_instr_valid", instr_valid, 0);
    chk("mw_reset_halted", halted, 0);
    reset = 0; clear_inputs();
    step();
    chk("mw_idle_running", running, 0);
    chk("mw_idle_pc", pc, 0);
    model_reset();

    // Reset during EXEC suppresses commit.
    do_start(0);
    step();
    chk("ex_instr_valid", instr_valid, 1);
    reset = 1;
    #1;
    chk("ex_reset_commit", commit, 0);
    step();
    chk("ex_reset_running", running, 0);

    // Reset dominates start.
    start = 1;
    step();
    chk("rst_dom_running", running, 0);
    chk("rst_dom_pc", pc, 0);
    reset = 0; start = 0;
    step();
    chk("rst_dom_idle", running, 0);
    model_reset();

    // Table returns to reset contents: entry 3 cleared, entry 6 is the halt vector.
    do_start(0);
    v = mk(0, 0, 0, 0, 0, 0, 0, 0); exec_instr(v, ref_next(model_pc, v));
    v = mk(3, 0, 0, 0, 0, 0, 0, 0); exec_instr(v, ref_next(model_pc, v));
    chk("tbl3_reset", pc, 0);
    v = mk(6, 0, 0, 0, 0, 0, 0, 0); exec_instr(v, ref_next(model_pc, v));
    chk("tbl6_halt_vec", pc, 200);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
